fir3_lane_serializer: RTL and testbench

- Output-side converter for the 3-way unfolded FIR.
- Takes the three parallel result lanes (sample indices 3k, 3k+1, 3k+2) qualified by VIN and buffers them as triples in a small FIFO.
- Re-emits them as a single serial sample stream, one sample per cycle, with a valid/ready handshake toward the downstream sink.
- Mirrors the serial-to-parallel packing done on the input side of the filter.

---
 rtl/fir3_lane_serializer.sv | 125 ++++++++++++
 tb/tb_fir3_lane_serializer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir3_lane_serializer.sv
// rtl/fir3_lane_serializer.sv - three-lane FIR result FIFO re-emitted as a serial sample stream
//
// Purpose: buffers parallel result triples {3k+2, 3k+1, 3k} in a DEPTH-entry
// FIFO and replays them one sample per cycle through a registered
// valid/ready output stage.
//
// Ports:
//   CLK        clock, rising edge
//   RST        synchronous reset, active-high
//   DIN3k      lane 0 sample (index 3k)
//   DIN3k1     lane 1 sample (index 3k+1)
//   DIN3k2     lane 2 sample (index 3k+2)
//   VIN        triple valid
//   IN_READY   FIFO can accept a triple (= !FULL)
//   DOUT       serial output sample, registered
//   VOUT       DOUT valid, registered
//   OUT_READY  downstream accepts DOUT this cycle
//   FULL       FIFO holds DEPTH triples
//   OVF        sticky overflow, cleared only by RST

module fir3_lane_serializer #(
    parameter int NBIT  = 8,
    parameter int DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NBIT-1:0] DIN3k,
    input  logic [NBIT-1:0] DIN3k1,
    input  logic [NBIT-1:0] DIN3k2,
    input  logic            VIN,
    output logic            IN_READY,
    output logic [NBIT-1:0] DOUT,
    output logic            VOUT,
    input  logic            OUT_READY,
    output logic            FULL,
    output logic            OVF
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;

    logic [3*NBIT-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [1:0]        lane_idx;

    logic              push_ok;
    logic              load;
    logic              pop;
    logic [3*NBIT-1:0] head;
    logic [NBIT-1:0]   head_lane;

    assign FULL     = (count == CNT_FULL);
    assign IN_READY = !FULL;

    // A triple arriving while full is dropped even if this cycle pops,
    // because FULL is judged on the count before the edge.
    assign push_ok = VIN && !FULL;

    // The output register refills when empty or being consumed; the FIFO
    // head is only retired once its lane 2 has moved into the register.
    assign load = (!VOUT || OUT_READY) && (count != '0);
    assign pop  = load && (lane_idx == LANE2);

    assign head = mem[rd_ptr];

    always_comb begin
        head_lane = head[NBIT-1:0];
        case (lane_idx)
            LANE1:   head_lane = head[2*NBIT-1:NBIT];
            LANE2:   head_lane = head[3*NBIT-1:2*NBIT];
            default: head_lane = head[NBIT-1:0];
        endcase
    end

    // Storage is not reset; the pointers alone define occupancy.
    always_ff @(posedge CLK) begin
        if (!RST && push_ok) begin
            mem[wr_ptr] <= {DIN3k2, DIN3k1, DIN3k};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            lane_idx <= LANE0;
            DOUT     <= '0;
            VOUT     <= 1'b0;
            OVF      <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (VIN && FULL) begin
                OVF <= 1'b1;
            end

            if (load) begin
                DOUT     <= head_lane;
                VOUT     <= 1'b1;
                lane_idx <= (lane_idx == LANE2) ? LANE0 : lane_idx + 1'b1;
            end else if (OUT_READY) begin
                VOUT <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir3_lane_serializer.sv
// tb/tb_fir3_lane_serializer.sv - randomized and directed bench for fir3_lane_serializer with queue-based model

module tb_fir3_lane_serializer;

    localparam int NBIT  = 8;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NBIT-1:0] d0 = '0;
    logic [NBIT-1:0] d1 = '0;
    logic [NBIT-1:0] d2 = '0;
    logic            vin = 1'b0;
    logic            in_ready;
    logic [NBIT-1:0] dout;
    logic            vout;
    logic            out_ready = 1'b0;
    logic            full;
    logic            ovf;

    fir3_lane_serializer #(.NBIT(NBIT), .DEPTH(DEPTH)) dut (
        .CLK       (clk),
        .RST       (rst),
        .DIN3k     (d0),
        .DIN3k1    (d1),
        .DIN3k2    (d2),
        .VIN       (vin),
        .IN_READY  (in_ready),
        .DOUT      (dout),
        .VOUT      (vout),
        .OUT_READY (out_ready),
        .FULL      (full),
        .OVF       (ovf)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Behavioural model: whole triples queued, plus the sample currently held
    // in the output register and how far into the head triple we have read.
    logic [3*NBIT-1:0] fq[$];
    logic [NBIT-1:0]   exp_q[$];
    logic [NBIT-1:0]   sink_q[$];
    int                m_lane = 0;
    logic              m_vout = 1'b0;
    logic [NBIT-1:0]   m_dout = '0;
    logic              m_ovf  = 1'b0;

    always @(posedge clk) begin
        int occ;
        if (rst) begin
            fq.delete();
            m_lane = 0;
            m_vout = 1'b0;
            m_dout = '0;
            m_ovf  = 1'b0;
        end else begin
            occ = fq.size();
            if ((!m_vout || out_ready) && occ > 0) begin
                m_dout = fq[0][m_lane*NBIT +: NBIT];
                m_vout = 1'b1;
                m_lane++;
                if (m_lane == 3) begin
                    m_lane = 0;
                    void'(fq.pop_front());
                end
            end else if (out_ready) begin
                m_vout = 1'b0;
            end
            if (vin) begin
                if (occ == DEPTH) begin
                    m_ovf = 1'b1;
                end else begin
                    fq.push_back({d2, d1, d0});
                    exp_q.push_back(d0);
                    exp_q.push_back(d1);
                    exp_q.push_back(d2);
                end
            end
        end
    end

    // Per-cycle comparison and sink log, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("vout", 32'(vout), 32'(m_vout));
            chk("dout", 32'(dout), 32'(m_dout));
            chk("full", 32'(full), 32'(fq.size() == DEPTH));
            chk("in_ready", 32'(in_ready), 32'(fq.size() != DEPTH));
            chk("ovf", 32'(ovf), 32'(m_ovf));
            if (!rst && vout && out_ready) begin
                sink_q.push_back(dout);
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vin = 1'b0;
        cycle();
        rst = 1'b0;
        sink_q.delete();
        exp_q.delete();
    endtask

    task automatic set_triple(input logic [NBIT-1:0] a, input logic [NBIT-1:0] b,
                              input logic [NBIT-1:0] c);
        d0 = a;
        d1 = b;
        d2 = c;
    endtask

    task automatic check_stream(input string name);
        int n;
        chk({name, "_len"}, 32'(sink_q.size()), 32'(exp_q.size()));
        n = (sink_q.size() < exp_q.size()) ? sink_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({name, "_sample"}, 32'(sink_q[i]), 32'(exp_q[i]));
        end
        sink_q.delete();
        exp_q.delete();
    endtask

    localparam bit PAT4 [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        // Test 1: reset state and single triple latency
        do_reset();
        chk_en = 1'b1;
        chk("rst_vout", 32'(vout), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        set_triple(8'h0A, 8'h14, 8'h1E);
        vin = 1'b1;
        cycle();
        vin = 1'b0;
        chk("t1_idle", 32'(vout), 32'd0);
        cycle();
        chk("t1_s0", 32'({vout, dout}), 32'h10A);
        cycle();
        chk("t1_s1", 32'({vout, dout}), 32'h114);
        cycle();
        chk("t1_s2", 32'({vout, dout}), 32'h11E);
        cycle();
        chk("t1_end", 32'(vout), 32'd0);
        chk("t1_flags", 32'({full, ovf}), 32'd0);
        check_stream("t1");

        // Test 2: burst of four back-to-back triples
        for (int k = 0; k < 4; k++) begin
            set_triple(8'(3*k+1), 8'(3*k+2), 8'(3*k+3));
            vin = 1'b1;
            cycle();
            chk("t2_not_full", 32'(full), 32'd0);
        end
        vin = 1'b0;
        cycles(14);
        chk("t2_len_lit", 32'(sink_q.size()), 32'd12);
        for (int i = 0; i < 12 && i < sink_q.size(); i++) begin
            chk("t2_lit", 32'(sink_q[i]), 32'(i + 1));
        end
        chk("t2_ovf", 32'(ovf), 32'd0);
        check_stream("t2");

        // Test 3: overflow with the sink stalled
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_triple(8'(16*k), 8'(16*k+1), 8'(16*k+2));
            vin = 1'b1;
            cycle();
            if (k == 3) begin
                chk("t3_full", 32'(full), 32'd1);
                chk("t3_in_ready", 32'(in_ready), 32'd0);
            end
        end
        vin = 1'b0;
        chk("t3_ovf", 32'(ovf), 32'd1);
        out_ready = 1'b1;
        cycles(16);
        chk("t3_len_lit", 32'(sink_q.size()), 32'd12);
        chk("t3_ovf_sticky", 32'(ovf), 32'd1);
        check_stream("t3");

        // Test 4: backpressure mid-triple with extreme values
        do_reset();
        out_ready = 1'b1;
        set_triple(8'h80, 8'h7F, 8'h01);
        vin = 1'b1;
        cycle();
        vin = 1'b0;
        for (int i = 0; i < 7; i++) begin
            out_ready = PAT4[i];
            cycle();
        end
        out_ready = 1'b1;
        cycles(4);
        chk("t4_len_lit", 32'(sink_q.size()), 32'd3);
        if (sink_q.size() == 3) begin
            chk("t4_lit0", 32'(sink_q[0]), 32'h80);
            chk("t4_lit1", 32'(sink_q[1]), 32'h7F);
            chk("t4_lit2", 32'(sink_q[2]), 32'h01);
        end
        check_stream("t4");

        // Test 5: pointer wrap at one triple per three cycles
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            set_triple(8'(3*k+100), 8'(3*k+101), 8'(3*k+102));
            vin = 1'b1;
            cycle();
            vin = 1'b0;
            chk("t5_full", 32'(full), 32'd0);
            cycles(2);
        end
        cycles(6);
        chk("t5_len_lit", 32'(sink_q.size()), 32'd30);
        check_stream("t5");

        // Test 6: reset while two triples are held and lane 1 is next
        do_reset();
        out_ready = 1'b0;
        set_triple(8'h11, 8'h22, 8'h33);
        vin = 1'b1;
        cycle();
        set_triple(8'h44, 8'h55, 8'h66);
        cycle();
        vin = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        sink_q.delete();
        exp_q.delete();
        chk("t6_vout", 32'(vout), 32'd0);
        chk("t6_dout", 32'(dout), 32'd0);
        chk("t6_full", 32'(full), 32'd0);
        chk("t6_ovf", 32'(ovf), 32'd0);
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        set_triple(8'hA1, 8'hB2, 8'hC3);
        vin = 1'b1;
        cycle();
        vin = 1'b0;
        cycle();
        chk("t6_first", 32'({vout, dout}), 32'h1A1);
        cycles(4);
        check_stream("t6");

        // Randomized traffic with occasional overflow
        do_reset();
        for (int i = 0; i < 600; i++) begin
            vin       = ($urandom_range(0, 99) < 35);
            out_ready = ($urandom_range(0, 99) < 70);
            set_triple(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                       8'($urandom_range(0, 255)));
            cycle();
        end
        vin       = 1'b0;
        out_ready = 1'b1;
        cycles(3*DEPTH + 6);
        check_stream("rand");

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
